// File: rtl/modi_rr_sched.sv
// Round-robin scheduler sharing one restoring N-bit modulo unit (D % DIV) among NREQ requesters.
// Requesters get a one-cycle ACK on grant; the result arrives on D_OUT with a per-requester R_OUT strobe.
module modi_rr_sched #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int CW   = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [NREQ-1:0]   r_in_i,
  input  logic [NREQ*N-1:0] d_in_i,
  input  logic [NREQ*N-1:0] div_in_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   r_out_o,
  output logic [N-1:0]      d_out_o,
  output logic              busy_o
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [LW-1:0]   last_q;
  logic [LW-1:0]   gnt_q;
  logic [LW-1:0]   pick_s;
  logic            pick_vld_s;
  int              pick_idx_s;
  logic [N-1:0]    dvd_q;
  logic [N-1:0]    dvs_q;
  logic [N-1:0]    d_out_q;
  logic [N-1:0]    cap_dvd_s;
  logic [N-1:0]    cap_dvs_s;
  logic [N:0]      rem_q;
  logic [N:0]      rem_d;
  logic [N:0]      t_s;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] r_out_q;
  logic            busy_q;

  // Rotating-priority pick: first requester after the last one served, with wrap.
  always_comb begin
    pick_s     = '0;
    pick_vld_s = 1'b0;
    pick_idx_s = 0;
    for (int i = 1; i <= NREQ; i++) begin
      pick_idx_s = (int'(last_q) + i) % NREQ;
      if (!pick_vld_s && r_in_i[pick_idx_s]) begin
        pick_vld_s = 1'b1;
        pick_s     = LW'(pick_idx_s);
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  assign cap_dvd_s = d_in_i[pick_s*N +: N];
  assign cap_dvs_s = div_in_i[pick_s*N +: N];

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    t_s = {rem_q[N-1:0], dvd_q[N-1]};
    if (t_s >= {1'b0, dvs_q}) begin
      rem_d = t_s - {1'b0, dvs_q};
    end else begin
      rem_d = t_s;
    end
  end

  // Controller, datapath and registered outputs; ACK/R_OUT clear on every edge so they only pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= LW'(NREQ - 1);
      gnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      d_out_q <= '0;
      ack_q   <= '0;
      r_out_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q   <= '0;
      r_out_q <= '0;
      if (en_i) begin
        case (state_q)
          IDLE: begin
            if (pick_vld_s) begin
              gnt_q         <= pick_s;
              dvd_q         <= cap_dvd_s;
              dvs_q         <= cap_dvs_s;
              rem_q         <= '0;
              cnt_q         <= CW'(N - 1);
              ack_q[pick_s] <= 1'b1;
              busy_q        <= 1'b1;
              // Divisors 0 and 1 both yield remainder 0, so the iteration is skipped.
              state_q       <= (cap_dvs_s <= N'(1)) ? DONE : CALC;
            end
          end
          CALC: begin
            dvd_q <= {dvd_q[N-2:0], 1'b0};
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              state_q <= DONE;
            end
          end
          DONE: begin
            d_out_q        <= rem_q[N-1:0];
            r_out_q[gnt_q] <= 1'b1;
            last_q         <= gnt_q;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign ack_o   = ack_q;
  assign r_out_o = r_out_q;
  assign d_out_o = d_out_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_modi_rr_sched.sv
// Self-checking bench for modi_rr_sched: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a transaction-level arbitration/remainder model.
module tb_modi_rr_sched;
  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int CW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NREQ-1:0]   r_in;
  logic [NREQ*N-1:0] d_in;
  logic [NREQ*N-1:0] div_in;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   r_out;
  logic [N-1:0]      d_out;
  logic              busy;

  logic [N-1:0] d_a [NREQ];
  logic [N-1:0] v_a [NREQ];

  int nerr = 0;
  int nchk = 0;
  int m_last;
  int cnt_g [NREQ];

  typedef struct {
    logic [N-1:0] d;
    logic [N-1:0] dv;
    logic [N-1:0] rem;
  } vec_t;
  vec_t vt [10];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NREQ; k++) begin : g_pack
    assign d_in[k*N +: N]   = d_a[k];
    assign div_in[k*N +: N] = v_a[k];
  end

  modi_rr_sched #(.N(N), .NREQ(NREQ), .CW(CW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (en),
    .r_in_i   (r_in),
    .d_in_i   (d_in),
    .div_in_i (div_in),
    .ack_o    (ack),
    .r_out_o  (r_out),
    .d_out_o  (d_out),
    .busy_o   (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for the next nonzero ACK or R_OUT; returns cycles waited and the pulse value.
  task automatic wait_pulse(input bit rout, input int limit, output int cyc, output logic [NREQ-1:0] val);
    cyc = 0;
    val = '0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      val = rout ? r_out : ack;
      if (val != '0) break;
    end
  endtask

  function automatic int pick(input int last, input logic [NREQ-1:0] req);
    for (int i = 1; i <= NREQ; i++) begin
      if (req[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] ref_rem(input logic [N-1:0] d, input logic [N-1:0] v);
    return (v == '0) ? '0 : d % v;
  endfunction

  task automatic run_one(input int k, input vec_t v);
    int c;
    logic [NREQ-1:0] p;
    d_a[k] = v.d;
    v_a[k] = v.dv;
    r_in   = NREQ'(1 << k);
    wait_pulse(1'b0, 5, c, p);
    chk("tbl_ack_lat", c, 1);
    chk("tbl_ack", p, 1 << k);
    chk("tbl_busy", busy, 1);
    r_in = '0;
    wait_pulse(1'b1, 40, c, p);
    chk("tbl_rout_lat", c, (v.dv <= 1) ? 1 : N + 1);
    chk("tbl_rout", p, 1 << k);
    chk("tbl_dout", d_out, v.rem);
    chk("tbl_idle", busy, 0);
  endtask

  task automatic new_req(input int k);
    d_a[k] = N'($urandom);
    case ($urandom_range(0, 7))
      0:       v_a[k] = '0;
      1:       v_a[k] = N'(1);
      2:       v_a[k] = N'($urandom_range(2, 15));
      3:       v_a[k] = N'(16'hFFFF - $urandom_range(0, 3));
      default: v_a[k] = N'($urandom);
    endcase
    r_in[k] = 1'b1;
  endtask

  task automatic run_rand(input logic [NREQ-1:0] mask, input int nops, input bit keep);
    int done = 0;
    int cyc = 0;
    int t_ack = 0;
    int lat = 0;
    int cur = -1;
    int eg;
    bit want_ack = 1'b0;
    logic [N-1:0] erem = '0;
    for (int k = 0; k < NREQ; k++) begin
      cnt_g[k] = 0;
      if (mask[k]) new_req(k);
    end
    want_ack = 1'b1;
    while (done < nops && cyc < nops * 30 + 100) begin
      @(negedge clk);
      cyc++;
      eg = pick(m_last, r_in);
      if (ack != '0) begin
        chk("rand_ack_idle", (cur == -1) ? 1 : 0, 1);
        chk("rand_ack", ack, (eg < 0) ? 0 : (1 << eg));
        cur   = (eg < 0) ? 0 : eg;
        erem  = ref_rem(d_a[cur], v_a[cur]);
        lat   = (v_a[cur] <= N'(1)) ? 1 : N + 1;
        t_ack = cyc;
        r_in[cur] = 1'b0;
        if (keep) new_req(cur);
      end else if (want_ack) begin
        chk("rand_next_grant", ack, (eg < 0) ? 0 : (1 << eg));
      end
      if (r_out != '0) begin
        chk("rand_rout", r_out, (cur < 0) ? 0 : (1 << cur));
        chk("rand_dout", d_out, erem);
        chk("rand_lat", cyc - t_ack, lat);
        if (cur >= 0) begin
          m_last = cur;
          cnt_g[cur]++;
        end
        cur = -1;
        done++;
      end
      if (done >= nops) begin
        r_in = '0;
      end else if (!keep) begin
        for (int k = 0; k < NREQ; k++) begin
          if (mask[k] && !r_in[k] && $urandom_range(0, 3) == 0) new_req(k);
        end
      end
      want_ack = (cur == -1) && (r_in != '0);
    end
    chk("rand_ops_done", done, nops);
    r_in = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int pulses;
    logic [NREQ-1:0] p;

    rst_n = 1'b0;
    en    = 1'b1;
    r_in  = '0;
    for (int k = 0; k < NREQ; k++) begin
      d_a[k] = '0;
      v_a[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_rout", r_out, 0);
    chk("rst_dout", d_out, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    vt[0] = '{16'd100,   16'd7,     16'd2};
    vt[1] = '{16'hFFFF,  16'h8000,  16'h7FFF};
    vt[2] = '{16'hFFFF,  16'hFFFF,  16'd0};
    vt[3] = '{16'd1234,  16'd0,     16'd0};
    vt[4] = '{16'd5,     16'd1,     16'd0};
    vt[5] = '{16'd3,     16'd10,    16'd3};
    vt[6] = '{16'd1234,  16'd100,   16'd34};
    vt[7] = '{16'hFFFF,  16'd256,   16'd255};
    vt[8] = '{16'd0,     16'd5,     16'd0};
    vt[9] = '{16'd1000,  16'd3,     16'd1};
    for (int i = 0; i < 10; i++) run_one(i % NREQ, vt[i]);

    // Reset mid-calculation: op from requester 2 is lost; arbitration restarts at requester 0.
    d_a[2] = 16'd100;
    v_a[2] = 16'd7;
    r_in   = 4'b0100;
    wait_pulse(1'b0, 5, c, p);
    chk("rst_mid_ack", p, 4'b0100);
    r_in = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ack0", ack, 0);
    chk("rst_mid_rout0", r_out, 0);
    chk("rst_mid_dout0", d_out, 0);
    chk("rst_mid_busy0", busy, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_out != '0) pulses++;
    end
    chk("rst_mid_no_rout", pulses, 0);
    rst_n  = 1'b1;
    d_a[1] = 16'd50;
    v_a[1] = 16'd9;
    d_a[2] = 16'd51;
    v_a[2] = 16'd9;
    r_in   = 4'b0110;
    wait_pulse(1'b0, 5, c, p);
    chk("rst_rel_first", p, 4'b0010);
    r_in[1] = 1'b0;
    wait_pulse(1'b1, 40, c, p);
    chk("rst_rel_dout1", d_out, 5);
    wait_pulse(1'b0, 5, c, p);
    chk("rst_rel_second", p, 4'b0100);
    r_in[2] = 1'b0;
    wait_pulse(1'b1, 40, c, p);
    chk("rst_rel_dout2", d_out, 6);

    // EN low for 5 cycles in CALC stretches latency by exactly 5 with no stray pulses.
    d_a[0] = 16'd100;
    v_a[0] = 16'd7;
    r_in   = 4'b0001;
    wait_pulse(1'b0, 5, c, p);
    chk("en_ack", p, 4'b0001);
    r_in = '0;
    repeat (4) @(negedge clk);
    en     = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ((ack | r_out) != '0) pulses++;
    end
    chk("en_frozen_pulses", pulses, 0);
    chk("en_frozen_busy", busy, 1);
    en = 1'b1;
    wait_pulse(1'b1, 40, c, p);
    chk("en_rout_lat", c, 13);
    chk("en_rout", p, 4'b0001);
    chk("en_dout", d_out, 2);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ((ack | r_out) != '0) pulses++;
    end
    chk("en_no_extra", pulses, 0);
    chk("dout_hold", d_out, 2);

    // All four request at once after reset: served 0,1,2,3, one op every N+2 cycles.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      d_a[k] = N'(50 + k);
      v_a[k] = 16'd9;
    end
    r_in = 4'b1111;
    for (int j = 0; j < NREQ; j++) begin
      wait_pulse(1'b0, 5, c, p);
      chk("all_ack_gap", c, 1);
      chk("all_ack_order", p, 1 << j);
      r_in[j] = 1'b0;
      wait_pulse(1'b1, 40, c, p);
      chk("all_rout_lat", c, N + 1);
      chk("all_dout", d_out, 5 + j);
    end

    m_last = NREQ - 1;
    run_rand(4'b1111, 60, 1'b0);
    run_rand(4'b1001, 100, 1'b1);
    chk("fair_req0", cnt_g[0], 50);
    chk("fair_req3", cnt_g[3], 50);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
